// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared command encodings, state enum and phase constants for the I2C bit controller
package i2c_pkg;

  localparam int PHASE_W = 2;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_STOP  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  function automatic state_e cmd_state(logic [1:0] cmd);
    case (cmd)
      CMD_START: cmd_state = ST_START;
      CMD_STOP:  cmd_state = ST_STOP;
      CMD_WRITE: cmd_state = ST_WRITE;
      default:   cmd_state = ST_READ;
    endcase
  endfunction

  // Returns {scl_oe, sda_oe} for a state/phase; 1 pulls the line low.
  function automatic logic [1:0] phase_oe(state_e st, logic [PHASE_W-1:0] ph, logic wr_bit);
    logic scl;
    logic sda;
    scl = 1'b0;
    sda = 1'b0;
    case (st)
      ST_START: begin
        scl = (ph == 2'd3);
        sda = (ph == 2'd2) || (ph == 2'd3);
      end
      ST_STOP: begin
        scl = (ph == 2'd0);
        sda = (ph == 2'd0) || (ph == 2'd1);
      end
      ST_WRITE: begin
        scl = (ph == 2'd0) || (ph == 2'd3);
        sda = ~wr_bit;
      end
      ST_READ: begin
        scl = (ph == 2'd0) || (ph == 2'd3);
        sda = 1'b0;
      end
      default: begin
        scl = 1'b0;
        sda = 1'b0;
      end
    endcase
    phase_oe = {scl, sda};
  endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - one-cycle tick on every level change of the divided clock
module edge_detect (
  input  logic clk_i,
  input  logic rst_n,
  input  logic sig_i,
  output logic tick_o
);

  logic sig_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign tick_o = sig_i ^ sig_q;

endmodule

// File: rtl/i2c_bit_ctrl.sv
// rtl/i2c_bit_ctrl.sv - I2C bit-level START/STOP/WRITE/READ sequencer
// Optional build macro: CLOCK_STRETCH_EN (slave may hold SCL low to stall phase P1).
module i2c_bit_ctrl
  import i2c_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       div_clk_i,
  output logic       div_en_o,
  input  logic [1:0] cmd_i,
  input  logic       cmd_wr_bit_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  output logic       done_o,
  output logic       rd_bit_o,
  output logic       arb_lost_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o
);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               wr_bit_q, wr_bit_d;
  logic               scl_oe_q, scl_oe_d;
  logic               sda_oe_q, sda_oe_d;
  logic               done_q, done_d;
  logic               rd_bit_q, rd_bit_d;
  logic               arb_lost_q, arb_lost_d;

  logic tick;
  logic busy;
  logic accept;
  logic abort;
  logic advance;

  edge_detect u_edge_detect (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .sig_i  (div_clk_i),
    .tick_o (tick)
  );

  assign busy   = (state_q != ST_IDLE);
  assign accept = cmd_valid_i && !busy;
  // Another master pulling SDA low while we release it for a 1 means we lost the bus.
  assign abort  = (state_q == ST_WRITE) && (phase_q == 2'd2) && wr_bit_q && !sda_i;

`ifdef CLOCK_STRETCH_EN
  assign advance = tick && !((phase_q == 2'd1) && !scl_i);
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign advance    = tick;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      wr_bit_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      rd_bit_q   <= 1'b0;
      arb_lost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wr_bit_q   <= wr_bit_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
      done_q     <= done_d;
      rd_bit_q   <= rd_bit_d;
      arb_lost_q <= arb_lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    wr_bit_d = wr_bit_q;
    if (!busy) begin
      phase_d = '0;
      if (cmd_valid_i) begin
        state_d  = cmd_state(cmd_i);
        wr_bit_d = cmd_wr_bit_i;
      end
    end else if (abort) begin
      state_d = ST_IDLE;
      phase_d = '0;
    end else if (advance) begin
      if (phase_q == 2'd3) begin
        state_d = ST_IDLE;
        phase_d = '0;
      end else begin
        phase_d = phase_q + 2'd1;
      end
    end
  end

  // Line enables are registered against the next state so they line up with state_q;
  // in IDLE they simply keep their last value.
  always_comb begin
    scl_oe_d   = scl_oe_q;
    sda_oe_d   = sda_oe_q;
    done_d     = 1'b0;
    rd_bit_d   = rd_bit_q;
    arb_lost_d = arb_lost_q;
    if (accept) begin
      arb_lost_d = 1'b0;
    end
    if (abort) begin
      scl_oe_d   = 1'b0;
      sda_oe_d   = 1'b0;
      done_d     = 1'b1;
      arb_lost_d = 1'b1;
    end else begin
      if (busy && advance && (phase_q == 2'd3)) begin
        done_d = 1'b1;
      end
      if ((state_q == ST_READ) && advance && (phase_q == 2'd2)) begin
        rd_bit_d = sda_i;
      end
      if (state_d != ST_IDLE) begin
        {scl_oe_d, sda_oe_d} = phase_oe(state_d, phase_d, wr_bit_d);
      end
    end
  end

  assign div_en_o    = busy;
  assign cmd_ready_o = !busy;
  assign done_o      = done_q;
  assign rd_bit_o    = rd_bit_q;
  assign arb_lost_o  = arb_lost_q;
  assign scl_oe_o    = scl_oe_q;
  assign sda_oe_o    = sda_oe_q;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// tb/tb_i2c_bit_ctrl.sv - self-checking bench for i2c_bit_ctrl against a transaction-level model
module tb_i2c_bit_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       div_clk = 1'b0;
  logic       div_en;
  logic [1:0] cmd = 2'b00;
  logic       cmd_wr_bit = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       done;
  logic       rd_bit;
  logic       arb_lost;
  logic       scl_i = 1'b1;
  logic       sda_i = 1'b1;
  logic       scl_oe;
  logic       sda_oe;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit rand_en = 1'b0;

`ifdef CLOCK_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  i2c_bit_ctrl dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .div_clk_i    (div_clk),
    .div_en_o     (div_en),
    .cmd_i        (cmd),
    .cmd_wr_bit_i (cmd_wr_bit),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .done_o       (done),
    .rd_bit_o     (rd_bit),
    .arb_lost_o   (arb_lost),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .scl_oe_o     (scl_oe),
    .sda_oe_o     (sda_oe)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (3) @(negedge clk);
    div_clk = ~div_clk;
  end

  initial forever begin
    @(negedge clk);
    if (rand_en) begin
      sda_i = ($urandom_range(0, 4) != 0);
      scl_i = STRETCH ? ($urandom_range(0, 7) != 0) : 1'($urandom);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {scl_oe, sda_oe} per command and phase, read off the bus waveforms (WRITE sda is ~bit).
  logic [1:0] oe_tab [4][4] = '{
    '{2'b00, 2'b00, 2'b01, 2'b11},
    '{2'b11, 2'b01, 2'b00, 2'b00},
    '{2'b10, 2'b00, 2'b00, 2'b10},
    '{2'b10, 2'b00, 2'b00, 2'b10}
  };

  bit         m_busy, m_done, m_rd, m_arb, m_scl, m_sda, m_div, m_wb;
  logic [1:0] m_cmd;
  int         m_ph;

  function automatic void m_load_oe();
    m_scl = oe_tab[m_cmd][m_ph][1];
    m_sda = (m_cmd == 2'd2) ? !m_wb : oe_tab[m_cmd][m_ph][0];
  endfunction

  always @(posedge clk) begin
    bit tk;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_rd = 0; m_arb = 0; m_scl = 0; m_sda = 0; m_div = 0; m_ph = 0;
    end else begin
      tk = (div_clk != m_div);
      m_div = div_clk;
      m_done = 0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1; m_cmd = cmd; m_wb = cmd_wr_bit; m_ph = 0; m_arb = 0;
          m_load_oe();
        end
      end else if (m_cmd == 2'd2 && m_ph == 2 && m_wb && !sda_i) begin
        m_busy = 0; m_done = 1; m_arb = 1; m_scl = 0; m_sda = 0;
      end else if (tk && !(STRETCH && m_ph == 1 && !scl_i)) begin
        if (m_cmd == 2'd3 && m_ph == 2) m_rd = sda_i;
        if (m_ph == 3) begin
          m_busy = 0; m_done = 1;
        end else begin
          m_ph++;
          m_load_oe();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready_o", cmd_ready, !m_busy);
      check("div_en_o", div_en, m_busy);
      check("done_o", done, m_done);
      check("scl_oe_o", scl_oe, m_scl);
      check("sda_oe_o", sda_oe, m_sda);
      check("rd_bit_o", rd_bit, m_rd);
      check("arb_lost_o", arb_lost, m_arb);
    end
  end

  task automatic send(input logic [1:0] c, input logic b);
    int n;
    n = 0;
    @(negedge clk);
    cmd = c; cmd_wr_bit = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = 2'($urandom);
    cmd_wr_bit = 1'($urandom);
    if (n >= 200) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(output logic [15:0] hist, output int n, output logic ok);
    logic [1:0] v;
    hist = '0; n = 0; ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      v = {scl_oe, sda_oe};
      if (n == 0 || v != hist[1:0]) begin
        hist = {hist[13:0], v};
        n++;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_phase(input int ph, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (m_busy && m_ph == ph) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] hist;
    int          n;
    logic        ok;
    logic [5:0]  wr_exp [3];
    logic        wr_bits [3];

    wr_bits = '{1'b1, 1'b0, 1'b1};
    wr_exp  = '{6'b100010, 6'b110111, 6'b100010};

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", cmd_ready, 1);
    check("rst_div_en", div_en, 0);
    check("rst_oe", {scl_oe, sda_oe}, 2'b00);
    check("rst_flags", {done, rd_bit, arb_lost}, 3'b000);
    rst_n = 1'b1;

    send(2'd0, 1'b0);
    wait_done(hist, n, ok);
    check("start_done_seen", ok, 1);
    check("start_ready_with_done", cmd_ready, 1);
    check("start_seq_len", n, 3);
    check("start_seq", hist[5:0], 6'b000111);

    for (int i = 0; i < 3; i++) begin
      send(2'd2, wr_bits[i]);
      wait_done(hist, n, ok);
      check("write_done_seen", ok, 1);
      check("write_seq", hist[5:0], wr_exp[i]);
      check("write_arb_lost", arb_lost, 0);
    end

    sda_i = 1'b1;
    send(2'd3, 1'b0);
    wait_done(hist, n, ok);
    @(negedge clk);
    check("read1_done_seen", ok, 1);
    check("read1_bit", rd_bit, 1);
    sda_i = 1'b0;
    send(2'd3, 1'b0);
    wait_done(hist, n, ok);
    @(negedge clk);
    check("read0_done_seen", ok, 1);
    check("read0_bit", rd_bit, 0);
    sda_i = 1'b1;

    send(2'd2, 1'b1);
    wait_phase(2, ok);
    check("abort_reach_p2", ok, 1);
    sda_i = 1'b0;
    @(negedge clk);
    check("abort_done", done, 1);
    check("abort_arb_lost", arb_lost, 1);
    check("abort_oe", {scl_oe, sda_oe}, 2'b00);
    check("abort_idle", cmd_ready, 1);
    sda_i = 1'b1;
    send(2'd0, 1'b0);
    check("arb_cleared_on_accept", arb_lost, 0);
    wait_done(hist, n, ok);
    check("post_abort_done_seen", ok, 1);

    send(2'd1, 1'b0);
    wait_phase(1, ok);
    check("stop_reach_p1", ok, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_div_en", div_en, 0);
    check("midrst_oe", {scl_oe, sda_oe}, 2'b00);
    check("midrst_flags", {done, rd_bit, arb_lost}, 3'b000);
    rst_n = 1'b1;
    cmd = 2'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("midrst_accept_busy", cmd_ready, 0);
    check("midrst_accept_en", div_en, 1);
    wait_done(hist, n, ok);
    check("midrst_start_done", ok, 1);

`ifdef CLOCK_STRETCH_EN
    send(2'd2, 1'b0);
    wait_phase(1, ok);
    check("stretch_reach_p1", ok, 1);
    scl_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("stretch_scl_oe", scl_oe, 0);
      check("stretch_busy", cmd_ready, 0);
    end
    scl_i = 1'b1;
    wait_done(hist, n, ok);
    check("stretch_done_seen", ok, 1);
`endif

    rand_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(2'($urandom_range(0, 3)), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_done(hist, n, ok);
    check("random_final_done", ok | cmd_ready, 1);
    rand_en = 1'b0;
    @(negedge clk);
    sda_i = 1'b1;
    scl_i = 1'b1;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_bit_ctrl.md
I2C_BIT_CTRL -- requirements
Module: i2c_bit_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk_i  input  1  system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 div_clk_i  input  1  divided clock from the clock divisor, sampled in the clk_i domain.
REQ-005 div_en_o  output  1  enable to the clock divisor; 1 whenever state != IDLE.
REQ-006 cmd_i  input  2  command: 00 START, 01 STOP, 10 WRITE, 11 READ.
REQ-007 cmd_wr_bit_i  input  1  bit to transmit for WRITE.
REQ-008 cmd_valid_i / cmd_ready_o  input / output  1 each  command handshake.
REQ-009 done_o  output  1  one-cycle pulse when a command completes or aborts.
REQ-010 rd_bit_o  output  1  bit sampled by the last READ; held until the next READ.
REQ-011 arb_lost_o  output  1  set with done_o when a WRITE loses arbitration; cleared on the next accept.
REQ-012 scl_i, sda_i  input  1 each  bus line levels.
REQ-013 scl_oe_o, sda_oe_o  output  1 each  open-drain pull-low enables; 1 drives the line low.

Function
REQ-014 tick SHALL be 1 for one cycle whenever div_clk_i differs from its registered value of the previous cycle.
REQ-015 States SHALL be IDLE, START, STOP, WRITE and READ, with a 2-bit phase counter (P0-P3) in each non-IDLE state.
REQ-016 cmd_ready_o SHALL be 1 only in IDLE.
REQ-017 On accept (valid && ready), the block SHALL latch cmd_i and cmd_wr_bit_i, enter the state for cmd_i at P0, and drive the P0 outputs in the next cycle.
REQ-018 Each tick SHALL advance the phase by one; a tick on P3 SHALL pulse done_o, return the block to IDLE, and drive cmd_ready_o to 1 in the same cycle.
REQ-019 START (scl_oe, sda_oe per phase) SHALL be: P0 (0,0), P1 (0,0), P2 (0,1), P3 (1,1).
REQ-020 STOP SHALL be: P0 (1,1), P1 (0,1), P2 (0,0), P3 (0,0).
REQ-021 WRITE SHALL be: P0 (1,~bit), P1 (0,~bit), P2 (0,~bit), P3 (1,~bit).
REQ-022 READ SHALL be: P0 (1,0), P1 (0,0), P2 (0,0), P3 (1,0).
REQ-023 READ SHALL load rd_bit_o from sda_i on the tick that ends P2.
REQ-024 In WRITE P2, bit=1 with sda_i=0 on any cycle SHALL abort the command.
REQ-025 On abort, the block SHALL set sda_oe_o=0 and scl_oe_o=0, pulse done_o, set arb_lost_o=1, and go to IDLE, all in the next cycle.
REQ-026 In IDLE, scl_oe_o and sda_oe_o SHALL hold their last values, so the bus stays owned between commands.
REQ-027 cmd_valid_i SHALL be ignored while busy, and an accepted command SHALL not be affected by later changes to cmd_i.

Reset
REQ-028 While rst_n=0 at a clk_i edge, the block SHALL enter state IDLE at P0.
REQ-029 Reset values SHALL be: scl_oe_o=0, sda_oe_o=0, done_o=0, rd_bit_o=0, arb_lost_o=0, div_en_o=0, cmd_ready_o=1, and the div_clk_i history register = 0.
REQ-030 A reset asserted mid-command SHALL abort the command with no done_o pulse.

Configuration
REQ-031 With CLOCK_STRETCH_EN defined, a tick in P1 of any command SHALL advance to P2 only when scl_i=1; otherwise the phase holds and the tick is dropped.
REQ-032 Without CLOCK_STRETCH_EN, scl_i SHALL be unused and every tick SHALL advance the phase.

Structure
REQ-033 The shared package i2c_pkg SHALL hold the command encodings, the state enum and the phase width constant.
REQ-034 The sub-module edge_detect SHALL generate tick from div_clk_i; everything else SHALL sit in i2c_bit_ctrl.

Verification
REQ-035 Bench clock: divisor model toggles div_clk_i every 3 cycles.
- START: scl/sda_oe follow (0,0),(0,0),(0,1),(1,1); done_o at the 4th tick; cmd_ready_o=1 the same cycle.
REQ-036 WRITE sequence: WRITE 1,0,1 after START.
- sda_oe_o = 0, 1, 0 in each bit's P0-P3.
- Three done_o pulses, arb_lost_o=0.
REQ-037 READ with sda_i=1 during P2: rd_bit_o=1 after done_o; repeat with sda_i=0: rd_bit_o=0.
REQ-038 WRITE bit=1 with sda_i forced 0 in P2:
- Next cycle: done_o=1, arb_lost_o=1, sda_oe_o=0, scl_oe_o=0, IDLE.
REQ-039 With CLOCK_STRETCH_EN, scl_i held 0 for 20 cycles in WRITE P1: phase stays P1 and scl_oe_o=0; P2 follows the first tick after scl_i=1.
REQ-040 Reset mid-STOP (P1): next cycle all outputs at reset values, no done_o; a new START is accepted the cycle after rst_n=1.
